subpixel_interpolation: RTL and testbench

SUBPIXEL_INTERPOLATION -- requirements
Module: subpixel_interpolation

---
 rtl/subpel_pkg.sv | 31 +++
 rtl/subpixel_interpolation_if.sv | 29 ++
 rtl/fir8_luma.sv | 29 ++
 rtl/subpixel_interpolation.sv | 119 +++++++++++
 tb/tb_subpixel_interpolation.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/subpel_pkg.sv
// rtl/subpel_pkg.sv - shared filter constants for the subpixel interpolator
package subpel_pkg;

  typedef enum logic [1:0] {
    FILT_A = 2'd0,
    FILT_B = 2'd1,
    FILT_C = 2'd2
  } filt_e;

  localparam int H_ROWS   = 15;
  localparam int V_ROWS   = 8;
  localparam int TERM_CNT = 23;

  // tap k lives at bits [8k +: 8], two's complement
  localparam logic [63:0] COEF_A = 64'h00_01_FB_11_3A_F6_04_FF;
  localparam logic [63:0] COEF_B = 64'hFF_04_F5_28_28_F5_04_FF;
  localparam logic [63:0] COEF_C = 64'hFF_04_F6_3A_11_FB_01_00;

  function automatic logic signed [15:0] coef(input filt_e f, input int k);
    logic [63:0] set;
    logic [7:0]  c8;
    case (f)
      FILT_A:  set = COEF_A;
      FILT_B:  set = COEF_B;
      default: set = COEF_C;
    endcase
    c8 = set[8*k +: 8];
    return {{8{c8[7]}}, c8};
  endfunction

endpackage

// File: rtl/subpixel_interpolation_if.sv
// rtl/subpixel_interpolation_if.sv - pixel window and result bundle of the interpolator
interface subpixel_interpolation_if;
  logic [1799:0] in_buffer;
  logic [2559:0] out_A;
  logic [2559:0] out_B;
  logic [2559:0] out_C;
  logic [959:0]  temp_A;
  logic [959:0]  temp_B;
  logic [959:0]  temp_C;
  logic [63:0]   fir_out_a;
  logic [63:0]   fir_out_b;
  logic [63:0]   fir_out_c;
  logic [119:0]  currentPixels;
  logic [7:0]    cnt;
  logic [7:0]    sel;
  logic          load_out;

  modport master (
    output in_buffer,
    input  out_A, out_B, out_C, temp_A, temp_B, temp_C,
    input  fir_out_a, fir_out_b, fir_out_c, currentPixels, cnt, sel, load_out
  );

  modport slave (
    input  in_buffer,
    output out_A, out_B, out_C, temp_A, temp_B, temp_C,
    output fir_out_a, fir_out_b, fir_out_c, currentPixels, cnt, sel, load_out
  );
endinterface

// File: rtl/fir8_luma.sv
// rtl/fir8_luma.sv - one 8-tap luma filter lane: rounded, clipped 8-bit result
module fir8_luma
  import subpel_pkg::*;
(
  input  logic [63:0] pix,
  input  filt_e       filt,
  output logic [7:0]  result
);

  logic signed [15:0] acc;
  logic signed [15:0] rnd;

  // worst-case partial sums stay within +/-22440, so 16 bits never wrap
  always_comb begin
    acc = '0;
    for (int k = 0; k < 8; k++) begin
      acc = acc + $signed({8'd0, pix[8*k +: 8]}) * coef(filt, k);
    end
    rnd = (acc + 16'sd32) >>> 6;
    if (rnd[15]) begin
      result = 8'd0;
    end else if (rnd[14:8] != 7'd0) begin
      result = 8'hFF;
    end else begin
      result = rnd[7:0];
    end
  end

endmodule

// File: rtl/subpixel_interpolation.sv
// rtl/subpixel_interpolation.sv - 15x15 window to 8x8 quarter-pel blocks, 15 horizontal then 8 vertical cycles
module subpixel_interpolation
  import subpel_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [1799:0] in_buffer,
  output logic [2559:0] out_A,
  output logic [2559:0] out_B,
  output logic [2559:0] out_C,
  output logic [959:0]  temp_A,
  output logic [959:0]  temp_B,
  output logic [959:0]  temp_C,
  output logic [63:0]   fir_out_a,
  output logic [63:0]   fir_out_b,
  output logic [63:0]   fir_out_c,
  output logic [119:0]  currentPixels,
  output logic [7:0]    cnt,
  output logic [7:0]    sel,
  output logic          load_out
);

  logic [959:0]  temp [3];
  logic [2559:0] outb [3];
  logic [7:0]    h_px [3][8];
  logic [63:0]   h_row [3];
  logic [63:0]   vcol_t [3][8];
  logic [63:0]   vcol_i [8];
  logic [7:0]    v_res [3][3][8];
  logic [7:0]    i_res [3][8];
  logic [2:0]    vrow;
  logic          h_pass;
  logic          v_pass;

  assign h_pass = cnt < 8'(H_ROWS);
  assign v_pass = !h_pass && (cnt < 8'(H_ROWS + V_ROWS));

  always_comb begin
    sel = 8'd0;
    if (h_pass) begin
      sel = cnt;
    end else if (v_pass) begin
      sel = cnt - 8'(H_ROWS);
    end
  end

  assign vrow          = sel[2:0];
  assign currentPixels = in_buffer[120*sel[3:0] +: 120];

  // column windows for the vertical pass: tap i is row vrow+i
  always_comb begin
    vcol_t = '{default: '0};
    vcol_i = '{default: '0};
    h_row  = '{default: '0};
    for (int x = 0; x < 8; x++) begin
      for (int i = 0; i < 8; i++) begin
        for (int t = 0; t < 3; t++) begin
          vcol_t[t][x][8*i +: 8] = temp[t][64*(int'(vrow) + i) + 8*x +: 8];
        end
        vcol_i[x][8*i +: 8] = in_buffer[120*(int'(vrow) + i) + 8*(x + 3) +: 8];
      end
      for (int t = 0; t < 3; t++) begin
        h_row[t][8*x +: 8] = h_px[t][x];
      end
    end
  end

  for (genvar t = 0; t < 3; t++) begin : g_lane
    for (genvar x = 0; x < 8; x++) begin : g_col
      fir8_luma u_h (.pix(currentPixels[8*x +: 64]), .filt(filt_e'(t)), .result(h_px[t][x]));
      fir8_luma u_i (.pix(vcol_i[x]), .filt(filt_e'(t)), .result(i_res[t][x]));
      for (genvar f = 0; f < 3; f++) begin : g_filt
        fir8_luma u_v (.pix(vcol_t[t][x]), .filt(filt_e'(f)), .result(v_res[t][f][x]));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      load_out <= 1'b0;
      for (int t = 0; t < 3; t++) begin
        temp[t] <= '0;
        outb[t] <= '0;
      end
    end else begin
      if (cnt < 8'(TERM_CNT)) begin
        cnt <= cnt + 8'd1;
      end
      load_out <= cnt >= 8'(TERM_CNT - 1);
      for (int t = 0; t < 3; t++) begin
        if (h_pass) begin
          temp[t][64*cnt[3:0] +: 64] <= h_row[t];
        end
        if (v_pass) begin
          // block 0 is horizontal-only, blocks 1..3 are A/B/C vertical, block 4 is integer column
          for (int x = 0; x < 8; x++) begin
            outb[t][64*int'(vrow) + 8*x +: 8] <= temp[t][64*(int'(vrow) + 3) + 8*x +: 8];
            for (int f = 0; f < 3; f++) begin
              outb[t][512*(f + 1) + 64*int'(vrow) + 8*x +: 8] <= v_res[t][f][x];
            end
            outb[t][2048 + 64*int'(vrow) + 8*x +: 8] <= i_res[t][x];
          end
        end
      end
    end
  end

  assign out_A     = outb[0];
  assign out_B     = outb[1];
  assign out_C     = outb[2];
  assign temp_A    = temp[0];
  assign temp_B    = temp[1];
  assign temp_C    = temp[2];
  assign fir_out_a = h_row[0];
  assign fir_out_b = h_row[1];
  assign fir_out_c = h_row[2];

endmodule

// File: tb/tb_subpixel_interpolation.sv
// tb/tb_subpixel_interpolation.sv - directed bench for subpixel_interpolation
module tb_subpixel_interpolation;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  logic [7:0] img [15][15];

  subpixel_interpolation_if bus ();

  subpixel_interpolation dut (
    .clk           (clk),
    .rst           (rst),
    .in_buffer     (bus.in_buffer),
    .out_A         (bus.out_A),
    .out_B         (bus.out_B),
    .out_C         (bus.out_C),
    .temp_A        (bus.temp_A),
    .temp_B        (bus.temp_B),
    .temp_C        (bus.temp_C),
    .fir_out_a     (bus.fir_out_a),
    .fir_out_b     (bus.fir_out_b),
    .fir_out_c     (bus.fir_out_c),
    .currentPixels (bus.currentPixels),
    .cnt           (bus.cnt),
    .sel           (bus.sel),
    .load_out      (bus.load_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
    end
  endtask

  function automatic int bad_bytes(input logic [2559:0] v, input int nbytes, input logic [7:0] val);
    int n = 0;
    for (int i = 0; i < nbytes; i++) begin
      if (v[8*i +: 8] !== val) n++;
    end
    return n;
  endfunction

  function automatic logic [119:0] exp_row(input int r);
    logic [119:0] row;
    for (int c = 0; c < 15; c++) row[8*c +: 8] = img[r][c];
    return row;
  endfunction

  task automatic drive_image();
    logic [1799:0] buf_v;
    for (int r = 0; r < 15; r++) buf_v[120*r +: 120] = exp_row(r);
    bus.in_buffer = buf_v;
  endtask

  task automatic fill(input logic [7:0] val);
    for (int r = 0; r < 15; r++)
      for (int c = 0; c < 15; c++) img[r][c] = val;
    drive_image();
  endtask

  task automatic run_block(input string tag, input bit trace);
    int edges;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    edges = 0;
    while (bus.load_out !== 1'b1 && edges < 40) begin
      if (trace) begin
        chk("trace cnt", bus.cnt, edges);
        if (edges < 15) begin
          chk("trace sel", bus.sel, edges);
          chk("trace row", bus.currentPixels, exp_row(edges));
        end else begin
          chk("trace vsel", bus.sel, edges - 15);
        end
      end
      @(negedge clk);
      edges++;
    end
    chk({tag, " load latency"}, edges, 23);
  endtask

  task automatic check_all(input string tag, input logic [7:0] val);
    chk({tag, " temp bytes"},
        bad_bytes(bus.temp_A, 120, val) + bad_bytes(bus.temp_B, 120, val) + bad_bytes(bus.temp_C, 120, val), 0);
    chk({tag, " out bytes"},
        bad_bytes(bus.out_A, 320, val) + bad_bytes(bus.out_B, 320, val) + bad_bytes(bus.out_C, 320, val), 0);
  endtask

  initial begin
    int waited;

    // reset state
    fill(8'h80);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("reset cnt", bus.cnt, 0);
    chk("reset load_out", bus.load_out, 0);
    chk("reset zero bytes", bad_bytes(bus.out_A, 320, 8'h00) + bad_bytes(bus.temp_C, 120, 8'h00), 0);

    // flat images
    run_block("flat80", 1'b0);
    check_all("flat80", 8'h80);
    fill(8'hFF);
    run_block("flatFF", 1'b0);
    check_all("flatFF", 8'hFF);
    fill(8'h00);
    run_block("flat00", 1'b0);
    check_all("flat00", 8'h00);

    // impulse at row 7, column 7
    fill(8'h00);
    img[7][7] = 8'hFF;
    drive_image();
    run_block("impulse", 1'b0);
    chk("impulse B blk0 row4", bus.out_B[64*4 +: 64], 64'h0010009F9F001000);
    chk("impulse A blk0 row4", bus.out_A[64*4 +: 64], 64'h001000E744000400);

    // vertical ramp with cycle-by-cycle timing trace
    for (int r = 0; r < 15; r++)
      for (int c = 0; c < 15; c++) img[r][c] = 8'(16 * r);
    drive_image();
    run_block("ramp", 1'b1);
    chk("done cnt", bus.cnt, 23);
    chk("done sel", bus.sel, 0);
    chk("done row", bus.currentPixels, exp_row(0));
    for (int y = 0; y < 8; y++) begin
      chk("ramp A blk4 row", bus.out_A[2048 + 64*y +: 64], {8{8'(16 * y + 52)}});
    end
    chk("ramp B blk4 row0", bus.out_B[2048 +: 64], {8{8'h38}});
    repeat (3) @(negedge clk);
    chk("hold cnt", bus.cnt, 23);
    chk("hold load_out", bus.load_out, 1);

    // reset in the middle of the horizontal pass
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    waited = 0;
    while (bus.cnt !== 8'd10 && waited < 30) begin
      @(negedge clk);
      waited++;
    end
    chk("mid reached cnt10", bus.cnt, 10);
    rst = 1'b1;
    @(negedge clk);
    chk("mid cnt", bus.cnt, 0);
    chk("mid load_out", bus.load_out, 0);
    chk("mid zero bytes",
        bad_bytes(bus.temp_A, 120, 8'h00) + bad_bytes(bus.temp_B, 120, 8'h00) + bad_bytes(bus.out_A, 320, 8'h00), 0);
    rst = 1'b0;
    waited = 0;
    while (bus.load_out !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    chk("mid load latency", waited, 23);
    chk("mid A blk4 row0", bus.out_A[2048 +: 64], {8{8'h34}});
    chk("mid B blk4 row0", bus.out_B[2048 +: 64], {8{8'h38}});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
